dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder for the pipelined core's M-stage data port: the core drives address, write data and write enable, and this block returns read data.
- Holds a word-organised RAM behind a small coalescing write buffer. The buffer drains to the array at a throttled rate to model a slow write port.
- Adds a memory-mapped I/O page: LED register, free-running cycle counter, status/error register.
- Read data is combinational, so the core can latch it into its W register on the next edge.

Parameters:
- DEPTH_WORDS, 64, number of 32-bit RAM words; RAM spans byte addresses 0 .. 4*DEPTH_WORDS-1.
- WB_DEPTH, 4, write-buffer entries (power of two, >=2).
- DRAIN_INTERVAL, 2, cycles per array write while the buffer is non-empty (>=1).

Ports:
- clk  in  1  system clock, all state on posedge.
- rst  in  1  synchronous, active-high reset.
- addr  in  32  byte address from core (ALU result of M stage).
- wdata  in  32  store data.
- mem_write  in  1  store enable, sampled at posedge.
- rdata  out  32  read data for addr, combinational.
- led  out  8  LED register contents.
- wb_full  out  1  write buffer holds WB_DEPTH entries (for hazard unit).
- wb_empty  out  1  write buffer holds 0 entries.
- err  out  1  OR of sticky error bits.

Behaviour:
- Reset: clk and rst as decided (reset rst, synchronous, active-high; clock clk).
  - Values after reset: buffer emptied with pending entries discarded, drain counter 0, led 0, cycle counter 0, err_misaligned 0, err_overflow 0, wb_empty 1, wb_full 0.
  - RAM contents are not reset.
  - Reset mid-drain aborts the drain, so no array write happens that cycle.
- Address map (word index = addr[31:2]):
  - RAM: addr < 4*DEPTH_WORDS.
  - 0xFFFF_0000 LED: read/write; bits [7:0] used, reads zero-extended.
  - 0xFFFF_0004 CYCLE: read-only 32-bit counter, +1 every cycle, wraps 0xFFFF_FFFF -> 0; writes ignored.
  - 0xFFFF_0008 STATUS: read {28'b0, err_overflow, err_misaligned, wb_full, wb_empty}. A write with wdata[3]/wdata[2] = 1 clears the corresponding sticky bit (W1C).
  - Anything else is unmapped: reads 0, writes ignored with no error.
- Reads:
  - addr[1:0] ignored.
  - RAM read returns the matching buffer entry's data if one matches the word index, else the array word.
  - Coalescing guarantees at most one match.
  - Stores become visible to a read of the same address on the cycle after the store's posedge.
- Stores (posedge, mem_write=1):
  - addr[1:0] != 0: store dropped, err_misaligned set, for any region.
  - Aligned RAM, word index matches a buffer entry: that entry's data is overwritten in place, with no new slot and no order change.
  - Aligned RAM, no match, buffer not full: enqueue at tail.
  - Aligned RAM, no match, buffer full: accepted only if the head drains in the same cycle (slot freed). Otherwise the store is dropped and err_overflow set.
  - LED/STATUS stores take effect at that posedge.
- Drain:
  - The drain counter increments each cycle while the buffer is non-empty and holds at 0 while empty.
  - When counter == DRAIN_INTERVAL-1 and the buffer is non-empty:
    - the head is written to the array;
    - the head is popped;
    - the counter returns to 0.
  - Entries drain in FIFO order.
  - A coalescing store to the head in its drain cycle: the array receives the new wdata.
- Occupancy:
  - Simultaneous enqueue + drain leaves the count unchanged.
  - Pointers wrap modulo WB_DEPTH.
  - wb_full and wb_empty are registered-state decodes, valid the cycle after the change.
- err = err_misaligned | err_overflow, sticky until W1C or reset. A W1C and a new error in the same cycle: the set wins.

Test Plan:
- Reset, then store 0x1234_5678 to 0x10; read 0x10 next cycle -> 0x1234_5678 from buffer with wb_empty=0; after DRAIN_INTERVAL cycles -> wb_empty=1 and array read still 0x1234_5678.
- Four stores on consecutive cycles to 0x0,0x4,0x8,0xC with DRAIN_INTERVAL=8, then a fifth to 0x20 before any drain -> wb_full=1, fifth dropped, err=1, STATUS bit3=1; a store of 0x8 to 0xFFFF_0008 clears it, and err=0 next cycle.
- Store 0xAAAA_AAAA then 0xBBBB_BBBB to 0x8 back-to-back -> single entry in buffer; read 0x8 = 0xBBBB_BBBB; after drain, array holds 0xBBBB_BBBB.
- Store to 0x6 -> no buffer change, err_misaligned=1; store 0x5A to 0xFFFF_0000 -> led=0x5A and a read of 0xFFFF_0000 returns 0x0000_005A.
- Read CYCLE at two points N cycles apart -> difference N. Force the counter near 0xFFFF_FFFE -> it wraps to 0.
- Fill the buffer with 3 entries, assert rst mid-drain -> wb_empty=1, led=0, err=0, and the array is unchanged for the undrained addresses.

Source files
------------

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder with coalescing write buffer and MMIO page
//
// Purpose: serves the core's M-stage data port. Stores to RAM go through a
// small coalescing write buffer that drains to the word array at a throttled
// rate. Reads are combinational and see buffered data first. An MMIO page at
// 0xFFFF_0000 holds the LED register, a free-running cycle counter and a
// status/error register.
//
// Ports:
//   clk        system clock, all state on posedge
//   rst        synchronous active-high reset
//   addr       byte address from the core
//   wdata      store data
//   mem_write  store enable
//   rdata      combinational read data for addr
//   led        LED register
//   wb_full    write buffer holds WB_DEPTH entries
//   wb_empty   write buffer holds no entries
//   err        OR of the sticky error bits
module dmem_responder #(
  parameter int DEPTH_WORDS    = 64,
  parameter int WB_DEPTH       = 4,
  parameter int DRAIN_INTERVAL = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        mem_write,
  output logic [31:0] rdata,
  output logic [7:0]  led,
  output logic        wb_full,
  output logic        wb_empty,
  output logic        err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int PW = $clog2(WB_DEPTH);
  localparam int CW = (DRAIN_INTERVAL > 1) ? $clog2(DRAIN_INTERVAL) : 1;
  localparam logic [31:0] RAM_BYTES = 32'(4 * DEPTH_WORDS);
  localparam logic [31:0] A_LED     = 32'hFFFF_0000;
  localparam logic [31:0] A_CYCLE   = 32'hFFFF_0004;
  localparam logic [31:0] A_STATUS  = 32'hFFFF_0008;

  logic [31:0]   r_ram     [DEPTH_WORDS];
  logic [AW-1:0] r_wb_addr [WB_DEPTH];
  logic [31:0]   r_wb_data [WB_DEPTH];
  logic [WB_DEPTH-1:0] r_wb_valid;
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [PW:0]   r_count;
  logic [CW-1:0] r_dcnt;
  logic [7:0]    r_led;
  logic [31:0]   r_cycle;
  logic          r_err_mis;
  logic          r_err_ov;

  logic          w_is_ram, w_is_led, w_is_cycle, w_is_status, w_aligned;
  logic [AW-1:0] w_ram_idx;
  logic          w_match;
  logic [PW-1:0] w_match_idx;
  logic          w_full, w_empty, w_drain;
  logic          w_st, w_st_ram, w_coal, w_enq, w_head_coal;
  logic          w_set_mis, w_set_ov, w_clr_mis, w_clr_ov;

  assign w_is_ram    = addr < RAM_BYTES;
  assign w_is_led    = addr[31:2] == A_LED[31:2];
  assign w_is_cycle  = addr[31:2] == A_CYCLE[31:2];
  assign w_is_status = addr[31:2] == A_STATUS[31:2];
  assign w_aligned   = addr[1:0] == 2'b00;
  assign w_ram_idx   = addr[AW+1:2];

  // Coalescing keeps word indices unique in the buffer, so at most one hit.
  always_comb begin
    w_match     = 1'b0;
    w_match_idx = '0;
    for (int i = 0; i < WB_DEPTH; i++) begin
      if (w_is_ram && r_wb_valid[i] && r_wb_addr[i] == w_ram_idx) begin
        w_match     = 1'b1;
        w_match_idx = PW'(i);
      end
    end
  end

  assign w_full   = r_count == (PW+1)'(WB_DEPTH);
  assign w_empty  = r_count == '0;
  assign w_drain  = !w_empty && (r_dcnt == CW'(DRAIN_INTERVAL - 1));

  assign w_st      = mem_write && w_aligned;
  assign w_st_ram  = w_st && w_is_ram;
  assign w_coal    = w_st_ram && w_match;
  // A full buffer still accepts a new word when the head leaves this cycle.
  assign w_enq     = w_st_ram && !w_match && (!w_full || w_drain);
  assign w_set_ov  = w_st_ram && !w_match && w_full && !w_drain;
  assign w_set_mis = mem_write && !w_aligned;
  assign w_clr_mis = w_st && w_is_status && wdata[2];
  assign w_clr_ov  = w_st && w_is_status && wdata[3];
  // Store hitting the head while it drains: the array must get the new data.
  assign w_head_coal = w_coal && w_drain && (w_match_idx == r_head);

  always_ff @(posedge clk) begin
    if (!rst && w_drain)
      r_ram[r_wb_addr[r_head]] <= w_head_coal ? wdata : r_wb_data[r_head];
  end

  always_ff @(posedge clk) begin
    if (w_coal)
      r_wb_data[w_match_idx] <= wdata;
    if (w_enq) begin
      r_wb_addr[r_tail] <= w_ram_idx;
      r_wb_data[r_tail] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_dcnt     <= '0;
      r_wb_valid <= '0;
      r_led      <= '0;
      r_cycle    <= '0;
      r_err_mis  <= 1'b0;
      r_err_ov   <= 1'b0;
    end else begin
      r_cycle <= r_cycle + 32'd1;
      if (w_empty || w_drain)
        r_dcnt <= '0;
      else
        r_dcnt <= r_dcnt + CW'(1);
      // Pop before push so a pop/push on the same slot leaves it valid.
      if (w_drain) begin
        r_wb_valid[r_head] <= 1'b0;
        r_head             <= r_head + PW'(1);
      end
      if (w_enq) begin
        r_wb_valid[r_tail] <= 1'b1;
        r_tail             <= r_tail + PW'(1);
      end
      r_count <= r_count + (PW+1)'(w_enq) - (PW+1)'(w_drain);
      if (w_st && w_is_led)
        r_led <= wdata[7:0];
      // Set beats W1C when both happen together.
      r_err_mis <= w_set_mis || (r_err_mis && !w_clr_mis);
      r_err_ov  <= w_set_ov  || (r_err_ov  && !w_clr_ov);
    end
  end

  always_comb begin
    rdata = 32'h0;
    if (w_is_ram)
      rdata = w_match ? r_wb_data[w_match_idx] : r_ram[w_ram_idx];
    else if (w_is_led)
      rdata = {24'h0, r_led};
    else if (w_is_cycle)
      rdata = r_cycle;
    else if (w_is_status)
      rdata = {28'h0, r_err_ov, r_err_mis, w_full, w_empty};
  end

  assign led      = r_led;
  assign wb_full  = w_full;
  assign wb_empty = w_empty;
  assign err      = r_err_mis | r_err_ov;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed self-checking bench for dmem_responder
module tb_dmem_responder;

  localparam logic [31:0] A_LED    = 32'hFFFF_0000;
  localparam logic [31:0] A_CYCLE  = 32'hFFFF_0004;
  localparam logic [31:0] A_STATUS = 32'hFFFF_0008;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        mem_write;
  logic [31:0] rdata;
  logic [7:0]  led;
  logic        wb_full;
  logic        wb_empty;
  logic        err;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] c1, c2;

  dmem_responder #(
    .DEPTH_WORDS(64),
    .WB_DEPTH(4),
    .DRAIN_INTERVAL(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .addr(addr),
    .wdata(wdata),
    .mem_write(mem_write),
    .rdata(rdata),
    .led(led),
    .wb_full(wb_full),
    .wb_empty(wb_empty),
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    mem_write = 1'b0;
    addr = a;
    #1;
    chk(tag, rdata, exp);
  endtask

  task automatic st(input logic [31:0] a, input logic [31:0] d);
    addr = a;
    wdata = d;
    mem_write = 1'b1;
    step();
    mem_write = 1'b0;
  endtask

  task automatic wait_empty(input string tag);
    int n = 0;
    while (!wb_empty && n < 60) begin
      step();
      n++;
    end
    chk(tag, 32'(wb_empty), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    addr = 32'h0;
    wdata = 32'h0;
    mem_write = 1'b0;
    step();
    step();
    rst = 1'b0;

    chk("rst_empty", 32'(wb_empty), 32'd1);
    chk("rst_full", 32'(wb_full), 32'd0);
    chk("rst_led", 32'(led), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk_rd("rst_cycle", A_CYCLE, 32'd0);

    // Single store, forwarded from buffer then drained after 8 cycles.
    st(32'h10, 32'h1234_5678);
    chk("st_notempty", 32'(wb_empty), 32'd0);
    chk_rd("st_fwd", 32'h10, 32'h1234_5678);
    repeat (7) step();
    chk("st_before_drain", 32'(wb_empty), 32'd0);
    step();
    chk("st_drained", 32'(wb_empty), 32'd1);
    chk_rd("st_array", 32'h10, 32'h1234_5678);

    st(32'h20, 32'h2020_2020);
    wait_empty("pre20_empty");

    // Fill buffer, fifth distinct store overflows.
    st(32'h0, 32'h0000_0100);
    st(32'h4, 32'h0000_0104);
    st(32'h8, 32'h0000_0108);
    st(32'hC, 32'h0000_010C);
    st(32'h20, 32'hDEAD_BEEF);
    chk("ov_full", 32'(wb_full), 32'd1);
    chk("ov_err", 32'(err), 32'd1);
    chk_rd("ov_status", A_STATUS, 32'hA);
    st(A_STATUS, 32'h8);
    chk("ov_w1c_err", 32'(err), 32'd0);
    chk_rd("ov_w1c_status", A_STATUS, 32'h2);
    wait_empty("ov_empty");
    chk_rd("ov_rd0", 32'h0, 32'h0000_0100);
    chk_rd("ov_rd4", 32'h4, 32'h0000_0104);
    chk_rd("ov_rd8", 32'h8, 32'h0000_0108);
    chk_rd("ov_rdC", 32'hC, 32'h0000_010C);
    chk_rd("ov_dropped", 32'h20, 32'h2020_2020);

    // Back-to-back coalesce into one entry.
    st(32'h8, 32'hAAAA_AAAA);
    st(32'h8, 32'hBBBB_BBBB);
    chk_rd("coal_fwd", 32'h8, 32'hBBBB_BBBB);
    repeat (7) step();
    chk("coal_single", 32'(wb_empty), 32'd1);
    chk_rd("coal_array", 32'h8, 32'hBBBB_BBBB);

    // Coalescing store to the head in its drain cycle.
    st(32'h4, 32'hCCCC_CCCC);
    repeat (7) step();
    st(32'h4, 32'hDDDD_DDDD);
    chk("headcoal_empty", 32'(wb_empty), 32'd1);
    chk_rd("headcoal_array", 32'h4, 32'hDDDD_DDDD);

    // Misaligned store, LED, W1C, unmapped.
    st(32'h6, 32'h0000_0099);
    chk("mis_empty", 32'(wb_empty), 32'd1);
    chk("mis_err", 32'(err), 32'd1);
    chk_rd("mis_status", A_STATUS, 32'h5);
    chk_rd("mis_nochange", 32'h4, 32'hDDDD_DDDD);
    st(A_LED, 32'hFFFF_FF5A);
    chk("led_out", 32'(led), 32'h5A);
    chk_rd("led_rd", A_LED, 32'h0000_005A);
    st(A_STATUS, 32'h4);
    chk("mis_w1c", 32'(err), 32'd0);
    st(32'h0000_1000, 32'h1);
    chk("unmap_err", 32'(err), 32'd0);
    chk("unmap_empty", 32'(wb_empty), 32'd1);
    chk_rd("unmap_rd", 32'h0000_1000, 32'h0);

    // Cycle counter delta and wrap.
    addr = A_CYCLE;
    #1;
    c1 = rdata;
    repeat (5) step();
    c2 = rdata;
    chk("cycle_delta", c2 - c1, 32'd5);
    force dut.r_cycle = 32'hFFFF_FFFE;
    chk_rd("cycle_forced", A_CYCLE, 32'hFFFF_FFFE);
    release dut.r_cycle;
    step();
    chk_rd("cycle_max", A_CYCLE, 32'hFFFF_FFFF);
    step();
    chk_rd("cycle_wrap", A_CYCLE, 32'h0);

    // Reset landing on the first drain edge must abort it.
    st(32'h2, 32'h1);
    st(32'h0, 32'h7777_0000);
    st(32'h4, 32'h7777_0001);
    st(32'h8, 32'h7777_0002);
    chk("pre_rst_err", 32'(err), 32'd1);
    repeat (5) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_empty", 32'(wb_empty), 32'd1);
    chk("mid_rst_led", 32'(led), 32'd0);
    chk("mid_rst_err", 32'(err), 32'd0);
    chk_rd("mid_rst_rd0", 32'h0, 32'h0000_0100);
    chk_rd("mid_rst_rd4", 32'h4, 32'hDDDD_DDDD);
    chk_rd("mid_rst_rd8", 32'h8, 32'hBBBB_BBBB);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
